ram_fifo_ctrl: RTL

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// ram_fifo_ctrl
//   FIFO controller that keeps its storage in an external RAM. The RAM has a
//   synchronous write port and an asynchronous read port, so reads have zero
//   latency and the head word is always visible on pop_data. The RAM array is
//   never reset: pop_valid is low whenever its contents are stale.
//
//   Optional feature: define RAM_FIFO_ALMOST_FULL_EN to add the registered
//   almost_full output (count >= data_depth - af_margin).
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-high reset (wins over flush)
//   flush          synchronous clear of pointers and count (wins over push/pop)
//   push_valid/push_ready/push_data   write-side handshake
//   pop_valid/pop_ready/pop_data      read-side handshake
//   count          occupancy, 0..data_depth
//   ram_cs_n, ram_wr_n                active-low RAM select / write enable
//   ram_wr_addr, ram_data_in          RAM write port
//   ram_rd_addr, ram_data_out         RAM asynchronous read port
//   almost_full    (RAM_FIFO_ALMOST_FULL_EN only) registered near-full flag
// -----------------------------------------------------------------------------
module ram_fifo_ctrl #(
  parameter int data_width = 16,
  parameter int data_depth = 8,
  parameter int af_margin  = 2,
  localparam int addr_width = $clog2(data_depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [data_width-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [data_width-1:0] pop_data,
  output logic [addr_width:0]   count,
  output logic                  ram_cs_n,
  output logic                  ram_wr_n,
  output logic [addr_width-1:0] ram_wr_addr,
  output logic [addr_width-1:0] ram_rd_addr,
  output logic [data_width-1:0] ram_data_in,
  input  logic [data_width-1:0] ram_data_out
`ifdef RAM_FIFO_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam logic [addr_width:0]   depth_c = (addr_width+1)'(data_depth);
  localparam logic [addr_width-1:0] last_c  = addr_width'(data_depth - 1);

  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic [addr_width:0]   count_load;
  logic                  push_acc;
  logic                  pop_acc;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [addr_width-1:0] ptr_inc(input logic [addr_width-1:0] p);
    return (p == last_c) ? '0 : p + 1'b1;
  endfunction

  // Handshake flags depend only on registered state (and rst), never on
  // push_valid / pop_ready, so no combinational loop through the peers.
  assign push_ready = ~rst & (count < depth_c);
  assign pop_valid  = (count != '0);

  // Flush discards whatever the peers offer in that cycle.
  assign push_acc = push_valid & push_ready & ~flush;
  assign pop_acc  = pop_valid & pop_ready & ~flush;

  // RAM is selected only for an accepted push; reads need no select.
  assign ram_cs_n    = ~push_acc;
  assign ram_wr_n    = ~push_acc;
  assign ram_wr_addr = wr_ptr;
  assign ram_data_in = push_data;
  assign ram_rd_addr = rd_ptr;
  assign pop_data    = ram_data_out;

  // Occupancy that will be loaded at the next edge (rst handled in the flop).
  always_comb begin
    // NOTE: default first so every path assigns count_load and no latch forms.
    count_load = count;
    if (flush) begin
      count_load = '0;
    end else if (push_acc && !pop_acc) begin
      count_load = count + 1'b1;
    end else if (pop_acc && !push_acc) begin
      count_load = count - 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: only pointers and count are reset; the RAM array itself never is.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_load;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
        if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

`ifdef RAM_FIFO_ALMOST_FULL_EN
  localparam int af_level_i = (data_depth > af_margin) ? data_depth - af_margin : 0;
  localparam logic [addr_width:0] af_level_c = (addr_width+1)'(af_level_i);

  // Registered from the value count takes at the same edge, so it tracks count
  // without lagging a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_load >= af_level_c);
    end
  end
`endif

endmodule
